result_writer: RTL and testbench

- Downstream drain stage of the result queue.
- Pops DATA_W-bit results from the queue's read side and packs PACK results into one memory word.
- Issues Avalon-MM style writes to consecutive addresses starting at a programmed base address.
- Raises a one-cycle done pulse once the programmed number of results has been written to memory.

---
 rtl/result_writer.sv | 162 ++++++++++++++++
 tb/tb_result_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writer.sv
// Result queue drain stage: pops results, packs PACK per memory word,
// and writes them to consecutive addresses from a programmed base.
module result_writer #(
    parameter int DATA_W = 32,
    parameter int PACK   = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         num_results,
    output logic                     busy,
    output logic                     done,
    input  logic                     rq_empty,
    output logic                     rq_re,
    input  logic [DATA_W-1:0]        rq_q,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_write,
    output logic [PACK*DATA_W-1:0]   mem_writedata,
    output logic [PACK*DATA_W/8-1:0] mem_byteenable,
    input  logic                     mem_waitrequest
);

    localparam int WD_W  = PACK * DATA_W;
    localparam int BE_W  = WD_W / 8;
    localparam int LBE_W = DATA_W / 8;
    localparam int LI_W  = $clog2(PACK + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [LI_W-1:0]   lane_q, lane_d;
    logic [WD_W-1:0]   data_q, data_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rq_re_q, rq_re_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Next-state, datapath and registered-output decode.
    // rq_re is registered, so the pop decision is made one cycle ahead
    // from the empty flag seen on entry to (or while waiting in) FETCH.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lane_d  = lane_q;
        data_d  = data_q;
        be_d    = be_q;
        rq_re_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = num_results;
                    lane_d = '0;
                    data_d = '0;
                    be_d   = '0;
                    if (num_results == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        rq_re_d = !rq_empty;
                    end
                end
            end
            S_FETCH: begin
                if (rq_re_q) begin
                    state_d = S_CAPTURE;
                end else begin
                    rq_re_d = !rq_empty;
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < PACK; i++) begin
                    if (lane_q == LI_W'(i)) begin
                        data_d[i*DATA_W +: DATA_W] = rq_q;
                        be_d[i*LBE_W +: LBE_W]     = '1;
                    end
                end
                lane_d = lane_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                if (lane_d == LI_W'(PACK) || rem_d == '0) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_FETCH;
                    rq_re_d = !rq_empty;
                end
            end
            S_WRITE: begin
                if (!mem_waitrequest) begin
                    addr_d = addr_q + STEP;
                    data_d = '0;
                    be_d   = '0;
                    lane_d = '0;
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        rq_re_d = !rq_empty;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        wr_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            rq_re_q <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            be_q    <= be_d;
            rq_re_q <= rq_re_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rq_re          = rq_re_q;
    assign mem_address    = addr_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = data_q;
    assign mem_byteenable = be_q;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: table of drain runs plus
// hand-written sequences for empty queue, stall, reset and re-start.
module tb_result_writer;

    localparam int DATA_W = 32;
    localparam int PACK   = 2;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       base_addr = '0;
    logic [15:0]       num_results = '0;
    logic              busy;
    logic              done;
    logic              rq_empty;
    logic              rq_re;
    logic [31:0]       rq_q = '0;
    logic [31:0]       mem_address;
    logic              mem_write;
    logic [63:0]       mem_writedata;
    logic [7:0]        mem_byteenable;
    logic              mem_waitrequest = 1'b0;

    result_writer #(
        .DATA_W(DATA_W),
        .PACK  (PACK),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .base_addr      (base_addr),
        .num_results    (num_results),
        .busy           (busy),
        .done           (done),
        .rq_empty       (rq_empty),
        .rq_re          (rq_re),
        .rq_q           (rq_q),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          n;
        logic [31:0] d0, d1, d2, d3;
        int          nw;
        logic [31:0] a0;
        logic [63:0] wd0;
        logic [7:0]  be0;
        logic [31:0] a1;
        logic [63:0] wd1;
        logic [7:0]  be1;
    } vec_t;

    vec_t tbl[6];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [31:0] fifo[$];
    int fifo_cnt = 0;
    bit pop_pending = 0;
    int rq_re_cnt = 0;
    int done_cnt = 0;
    int underflow = 0;
    logic [31:0] wr_a[$];
    logic [63:0] wr_d[$];
    logic [7:0]  wr_b[$];

    assign rq_empty = (fifo_cnt == 0);

    // Queue model: read data appears the cycle after rdreq.
    always @(posedge clk) begin
        cyc++;
        if (pop_pending) begin
            rq_q <= fifo.pop_front();
            fifo_cnt = fifo.size();
            pop_pending = 0;
        end
    end

    // Monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rq_re) begin
            rq_re_cnt++;
            if (fifo_cnt == 0) underflow++;
            else pop_pending = 1;
        end
        if (done) done_cnt++;
        if (mem_write && !mem_waitrequest) begin
            wr_a.push_back(mem_address);
            wr_d.push_back(mem_writedata);
            wr_b.push_back(mem_byteenable);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        fifo.push_back(v);
        fifo_cnt = fifo.size();
    endtask

    task automatic clear_mon();
        rq_re_cnt = 0;
        done_cnt = 0;
        underflow = 0;
        wr_a.delete();
        wr_d.delete();
        wr_b.delete();
    endtask

    task automatic pulse_start(input logic [31:0] b, input int n);
        base_addr = b;
        num_results = 16'(n);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen;
        seen = 0;
        lat = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat = cyc - start_cyc;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        chk({tag, "_busy_done_after"}, {62'd0, busy, done}, 64'd0);
        tick();
    endtask

    task automatic check_writes(input string tag, input int nrq,
                                input int nw,
                                input logic [31:0] a0,
                                input logic [63:0] d0,
                                input logic [7:0] b0,
                                input logic [31:0] a1,
                                input logic [63:0] d1,
                                input logic [7:0] b1);
        chk({tag, "_rq_re_cnt"}, 64'(rq_re_cnt), 64'(nrq));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_underflow"}, 64'(underflow), 64'd0);
        chk({tag, "_wr_cnt"}, 64'(wr_a.size()), 64'(nw));
        if (nw >= 1 && wr_a.size() >= 1) begin
            chk({tag, "_addr0"}, 64'(wr_a[0]), 64'(a0));
            chk({tag, "_data0"}, wr_d[0], d0);
            chk({tag, "_be0"}, 64'(wr_b[0]), 64'(b0));
        end
        if (nw >= 2 && wr_a.size() >= 2) begin
            chk({tag, "_addr1"}, 64'(wr_a[1]), 64'(a1));
            chk({tag, "_data1"}, wr_d[1], d1);
            chk({tag, "_be1"}, 64'(wr_b[1]), 64'(b1));
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] b,
                           input int n,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input int nw,
                           input logic [31:0] a0, input logic [63:0] wd0,
                           input logic [7:0] be0,
                           input logic [31:0] a1, input logic [63:0] wd1,
                           input logic [7:0] be1);
        tbl[i].base = b;
        tbl[i].n = n;
        tbl[i].d0 = d0;
        tbl[i].d1 = d1;
        tbl[i].d2 = d2;
        tbl[i].d3 = d3;
        tbl[i].nw = nw;
        tbl[i].a0 = a0;
        tbl[i].wd0 = wd0;
        tbl[i].be0 = be0;
        tbl[i].a1 = a1;
        tbl[i].wd1 = wd1;
        tbl[i].be1 = be1;
    endtask

    task automatic run_vec(input int i);
        string tag;
        int lat;
        logic [31:0] dd[4];
        tag = $sformatf("vec%0d", i);
        dd[0] = tbl[i].d0;
        dd[1] = tbl[i].d1;
        dd[2] = tbl[i].d2;
        dd[3] = tbl[i].d3;
        clear_mon();
        for (int k = 0; k < tbl[i].n; k++) push(dd[k]);
        pulse_start(tbl[i].base, tbl[i].n);
        wait_done(tag, lat);
        chk({tag, "_latency"}, 64'(lat),
            64'(2 * tbl[i].n + tbl[i].nw + 1));
        check_writes(tag, tbl[i].n, tbl[i].nw,
                     tbl[i].a0, tbl[i].wd0, tbl[i].be0,
                     tbl[i].a1, tbl[i].wd1, tbl[i].be1);
    endtask

    initial begin
        int lat;
        bit seen;

        set_vec(0, 32'h1000, 4, 32'hA, 32'hB, 32'hC, 32'hD, 2,
                32'h1000, 64'h0000000B_0000000A, 8'hFF,
                32'h1008, 64'h0000000D_0000000C, 8'hFF);
        set_vec(1, 32'h2000, 3, 32'h1, 32'h2, 32'h3, 32'h0, 2,
                32'h2000, 64'h00000002_00000001, 8'hFF,
                32'h2008, 64'h00000000_00000003, 8'h0F);
        set_vec(2, 32'h3000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0,
                32'h0, 64'h0, 8'h0, 32'h0, 64'h0, 8'h0);
        set_vec(3, 32'hFFFF_FFF8, 4, 32'h11, 32'h22, 32'h33, 32'h44, 2,
                32'hFFFF_FFF8, 64'h00000022_00000011, 8'hFF,
                32'h0000_0000, 64'h00000044_00000033, 8'hFF);
        set_vec(4, 32'h40, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1,
                32'h40, 64'h00000000_DEADBEEF, 8'h0F,
                32'h0, 64'h0, 8'h0);
        set_vec(5, 32'h100, 2, 32'h5, 32'h6, 32'h0, 32'h0, 1,
                32'h100, 64'h00000006_00000005, 8'hFF,
                32'h0, 64'h0, 8'h0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rq_re", 64'(rq_re), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_wdata", mem_writedata, 64'd0);
        chk("rst_be", 64'(mem_byteenable), 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Queue runs dry mid-run, then refills.
        clear_mon();
        push(32'h100);
        push(32'h101);
        pulse_start(32'h5000, 4);
        repeat (8) tick();
        chk("empty_rq_before", 64'(rq_re_cnt), 64'd2);
        repeat (10) tick();
        chk("empty_rq_during", 64'(rq_re_cnt), 64'd2);
        chk("empty_busy", 64'(busy), 64'd1);
        push(32'h102);
        push(32'h103);
        wait_done("empty", lat);
        check_writes("empty", 4, 2,
                     32'h5000, 64'h00000101_00000100, 8'hFF,
                     32'h5008, 64'h00000103_00000102, 8'hFF);

        // Five-cycle stall on the first write.
        clear_mon();
        push(32'h77);
        push(32'h88);
        mem_waitrequest = 1'b1;
        pulse_start(32'h6000, 2);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mem_write) seen = 1;
        end
        chk("stall_write_seen", 64'(seen), 64'd1);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk($sformatf("stall%0d_wr", s), 64'(mem_write), 64'd1);
            chk($sformatf("stall%0d_addr", s), 64'(mem_address),
                64'h6000);
            chk($sformatf("stall%0d_data", s), mem_writedata,
                64'h00000088_00000077);
            chk($sformatf("stall%0d_be", s), 64'(mem_byteenable),
                64'hFF);
        end
        tick();
        mem_waitrequest = 1'b0;
        wait_done("stall", lat);
        check_writes("stall", 2, 1,
                     32'h6000, 64'h00000088_00000077, 8'hFF,
                     32'h0, 64'h0, 8'h0);

        // Reset during WRITE, then a fresh two-result run.
        clear_mon();
        push(32'h1);
        push(32'h2);
        push(32'h3);
        push(32'h4);
        mem_waitrequest = 1'b1;
        pulse_start(32'h7000, 4);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mem_write) seen = 1;
        end
        chk("rstw_write_seen", 64'(seen), 64'd1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("rstw_mem_write", 64'(mem_write), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_addr", 64'(mem_address), 64'd0);
        chk("rstw_wdata", mem_writedata, 64'd0);
        chk("rstw_be", 64'(mem_byteenable), 64'd0);
        tick();
        clear_mon();
        pulse_start(32'h8000, 2);
        wait_done("rstw", lat);
        chk("rstw_latency", 64'(lat), 64'd6);
        check_writes("rstw", 2, 1,
                     32'h8000, 64'h00000004_00000003, 8'hFF,
                     32'h0, 64'h0, 8'h0);

        // start while busy is ignored.
        clear_mon();
        push(32'h55);
        push(32'h66);
        pulse_start(32'h9000, 2);
        tick();
        base_addr = 32'hA000;
        num_results = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("rebusy", lat);
        chk("rebusy_latency", 64'(lat), 64'd6);
        check_writes("rebusy", 2, 1,
                     32'h9000, 64'h00000066_00000055, 8'hFF,
                     32'h0, 64'h0, 8'h0);
        chk("rebusy_fifo_left", 64'(fifo_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
